// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code-set-2 key event encoder.
// Byte values, FSM states, the pause sequence and ps2_key field positions live here.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

  // Device responses that never represent a key and are silently dropped
  localparam logic [7:0] PS2_RSP_BAT    = 8'hAA;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
  localparam logic [7:0] PS2_RSP_ECHO   = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE,
    GAP
  } ps2_state_e;

  // Bytes that follow the leading E1 of the pause key
  localparam logic [7:0] PAUSE_SEQ [0:6] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  localparam logic [2:0] PAUSE_LAST = 3'd6;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

endpackage

// File: rtl/ps2_key_encoder.sv
// Converts a raw PS/2 set-2 byte stream into 11-bit ps2_key events (toggle, pressed, extended, code).
// One counter is shared between the post-event gap and the prefix timeout.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int MIN_GAP        = 4,
  parameter int PREFIX_TIMEOUT = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [7:0]  byte_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        proto_err
);

  localparam int CNT_MAX = (MIN_GAP > PREFIX_TIMEOUT) ? MIN_GAP : PREFIX_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(MIN_GAP - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(PREFIX_TIMEOUT - 1);

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [10:0]   key_q, key_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;

  logic accept;
  logic emit, emitPressed, emitExt, raiseErr;

  assign byte_ready = (state_q != GAP);
  assign accept     = byte_valid & byte_ready;
  assign ps2_key    = key_q;
  assign key_strobe = strobe_q;
  assign proto_err  = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      key_q    <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      key_q    <= key_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    key_d       = key_q;
    strobe_d    = 1'b0;
    err_d       = 1'b0;
    emit        = 1'b0;
    emitPressed = 1'b0;
    emitExt     = 1'b0;
    raiseErr    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          case (byte_data)
            PS2_EXT:   state_d = EXT;
            PS2_BRK:   state_d = BRK;
            PS2_PAUSE: begin
              state_d = PAUSE;
              idx_d   = '0;
            end
            PS2_RSP_BAT, PS2_RSP_ACK, PS2_RSP_RESEND, PS2_RSP_ECHO: state_d = IDLE;
            default: begin
              emit        = 1'b1;
              emitPressed = 1'b1;
            end
          endcase
        end
      end

      EXT, BRK, EXT_BRK, PAUSE: begin
        if (accept) begin
          cnt_d = '0;
          case (state_q)
            EXT: begin
              if (byte_data == PS2_BRK) state_d = EXT_BRK;
              else if (byte_data == PS2_FAKE_SHIFT) state_d = IDLE;
              else if (byte_data == PS2_EXT || byte_data == PS2_PAUSE) raiseErr = 1'b1;
              else begin
                emit        = 1'b1;
                emitPressed = 1'b1;
                emitExt     = 1'b1;
              end
            end
            BRK: begin
              if (byte_data == PS2_EXT || byte_data == PS2_PAUSE || byte_data == PS2_BRK)
                raiseErr = 1'b1;
              else emit = 1'b1;
            end
            EXT_BRK: begin
              if (byte_data == PS2_FAKE_SHIFT) state_d = IDLE;
              else if (byte_data == PS2_EXT || byte_data == PS2_PAUSE || byte_data == PS2_BRK)
                raiseErr = 1'b1;
              else begin
                emit    = 1'b1;
                emitExt = 1'b1;
              end
            end
            default: begin
              // Pause has no break event; its final matching byte reports an extended make of 77
              if (byte_data != PAUSE_SEQ[idx_q]) raiseErr = 1'b1;
              else if (idx_q == PAUSE_LAST) begin
                emit        = 1'b1;
                emitPressed = 1'b1;
                emitExt     = 1'b1;
              end else idx_d = idx_q + 3'd1;
            end
          endcase
        end else if (cnt_q == TO_LAST) begin
          raiseErr = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (raiseErr) begin
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end

    if (emit) begin
      key_d    = {~key_q[KEY_TOGGLE], emitPressed, emitExt, byte_data};
      strobe_d = 1'b1;
      state_d  = GAP;
      cnt_d    = '0;
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench for ps2_key_encoder: directed byte sequences push hand-computed
// ps2_key words (toggle included) and error tokens; a negedge monitor pops and compares.
module tb_ps2_key_encoder;

  localparam int MIN_GAP        = 4;
  localparam int PREFIX_TIMEOUT = 64;

  logic        clock;
  logic        reset;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        proto_err;

  logic [10:0] expQ[$];
  int          errPending;
  int          compared;
  int          mismatched;
  int          waited;

  ps2_key_encoder #(
    .MIN_GAP(MIN_GAP),
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .byte_data(byte_data),
    .ps2_key(ps2_key),
    .key_strobe(key_strobe),
    .proto_err(proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every strobe must match the oldest expected word, every error must be expected
  always @(negedge clock) begin
    if (!reset) begin
      if (key_strobe && proto_err) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL strobe_err_overlap: both outputs high, required never together");
      end
      if (key_strobe) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_event: ps2_key=%h, required no event", ps2_key);
        end else begin
          logic [10:0] exp;
          exp = expQ.pop_front();
          if (ps2_key !== exp) begin
            mismatched++;
            $display("[TB] FAIL event_word: ps2_key=%h, required %h", ps2_key, exp);
          end
        end
      end
      if (proto_err) begin
        compared++;
        if (errPending == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_proto_err: proto_err=1, required 0");
        end else begin
          errPending--;
        end
      end
    end
  end

  // Watchdog so a stuck handshake still reaches a verdict
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns once the byte was accepted on an edge
  task automatic applyStimulus(input logic [7:0] b, output int stalls);
    stalls     = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && stalls < 100) begin
      @(posedge clock);
      #1;
      stalls++;
    end
    if (!byte_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL byte_ready_timeout: byte_ready=0 after %0d clocks, required 1", stalls);
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sendBytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) applyStimulus(bytes[i], waited);
    byte_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    byte_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Let pending outputs drain, then require every expected event and error to have appeared
  task automatic checkOutput(input string name);
    idleCycles(MIN_GAP + 4);
    compared++;
    if (expQ.size() != 0 || errPending != 0) begin
      mismatched++;
      $display("[TB] FAIL %s: %0d events and %0d errors outstanding, required 0 and 0",
               name, expQ.size(), errPending);
      expQ.delete();
      errPending = 0;
    end
  endtask

  initial begin
    errPending = 0;
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    checkEq("reset_ps2_key", 32'(ps2_key), 32'h000);
    checkEq("reset_key_strobe", 32'(key_strobe), 32'h0);
    checkEq("reset_proto_err", 32'(proto_err), 32'h0);
    checkEq("reset_byte_ready", 32'(byte_ready), 32'h1);

    expQ.push_back(11'h61C);
    expQ.push_back(11'h01C);
    sendBytes('{8'h1C, 8'hF0, 8'h1C});
    checkOutput("make_break_1c");

    expQ.push_back(11'h775);
    expQ.push_back(11'h175);
    sendBytes('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
    checkOutput("extended_75");

    expQ.push_back(11'h777);
    sendBytes('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
    checkOutput("pause_sequence");

    sendBytes('{8'hE1, 8'h14, 8'h77});
    errPending++;
    sendBytes('{8'h00});
    checkOutput("pause_mismatch");

    sendBytes('{8'hE0, 8'h12, 8'hE0, 8'hF0, 8'h12, 8'hAA, 8'hFA});
    checkOutput("dropped_bytes");

    // Back-to-back: the second byte must stall exactly for the gap
    expQ.push_back(11'h216);
    expQ.push_back(11'h61E);
    applyStimulus(8'h16, waited);
    applyStimulus(8'h1E, waited);
    byte_valid = 1'b0;
    checkEq("gap_length", 32'(waited), 32'(MIN_GAP));
    checkOutput("back_to_back");

    sendBytes('{8'hE0});
    errPending++;
    idleCycles(PREFIX_TIMEOUT + 8);
    expQ.push_back(11'h229);
    sendBytes('{8'h29});
    checkOutput("prefix_timeout");

    sendBytes('{8'hF0});
    reset = 1'b1;
    #1;
    checkEq("midreset_ps2_key", 32'(ps2_key), 32'h000);
    checkEq("midreset_byte_ready", 32'(byte_ready), 32'h1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    expQ.push_back(11'h61C);
    sendBytes('{8'h1C});
    checkOutput("after_reset_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
